// File: rtl/seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : seq_serializer
// Description : Parallel-to-serial stage. Accepts WIDTH-bit words over a
//               valid/ready handshake through a one-word holding buffer and
//               shifts them out one bit per clock, back to back with no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             signal,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] buf_data, buf_data_nxt;
    logic             buf_full, buf_full_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             signal_nxt;
    logic             bit_valid_nxt;
    logic             word_done_nxt;
    logic             accept;
    logic             load;

    // Bit-order helpers: first bit of the buffered word, the buffered word with
    // that bit consumed, the next bit of the shifter and the shifter advanced.
    logic             buf_first;
    logic [WIDTH-1:0] buf_rest;
    logic             sh_head;
    logic [WIDTH-1:0] sh_rest;

    // Select head bit and shift direction according to MSB_FIRST.
    always_comb begin
        if (MSB_FIRST) begin
            buf_first = buf_data[WIDTH-1];
            buf_rest  = {buf_data[WIDTH-2:0], 1'b0};
            sh_head   = shreg[WIDTH-1];
            sh_rest   = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            buf_first = buf_data[0];
            buf_rest  = {1'b0, buf_data[WIDTH-1:1]};
            sh_head   = shreg[0];
            sh_rest   = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // Next-state and next-output logic; clr overrides load and accept.
    always_comb begin
        state_nxt     = state;
        buf_data_nxt  = buf_data;
        buf_full_nxt  = buf_full;
        shreg_nxt     = shreg;
        cnt_nxt       = cnt;
        signal_nxt    = IDLE_BIT;
        bit_valid_nxt = 1'b0;
        word_done_nxt = 1'b0;
        load          = 1'b0;
        accept        = in_valid & in_ready;

        case (state)
            IDLE: begin
                if (buf_full) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    cnt_nxt       = cnt - CNT_ONE;
                    signal_nxt    = sh_head;
                    bit_valid_nxt = 1'b1;
                    shreg_nxt     = sh_rest;
                    word_done_nxt = (cnt == CNT_ONE);
                end else if (buf_full) begin
                    load = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Loading the shifter frees the buffer and presents the first bit.
        if (load) begin
            shreg_nxt     = buf_rest;
            signal_nxt    = buf_first;
            bit_valid_nxt = 1'b1;
            cnt_nxt       = CNT_LAST;
            state_nxt     = SHIFT;
            buf_full_nxt  = 1'b0;
        end

        // Accept only happens while the buffer is empty, so never with load.
        if (accept) begin
            buf_data_nxt = in_data;
            buf_full_nxt = 1'b1;
        end

        if (clr) begin
            state_nxt     = IDLE;
            buf_full_nxt  = 1'b0;
            cnt_nxt       = '0;
            signal_nxt    = IDLE_BIT;
            bit_valid_nxt = 1'b0;
            word_done_nxt = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            buf_data  <= '0;
            buf_full  <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            signal    <= IDLE_BIT;
            bit_valid <= 1'b0;
            word_done <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            buf_data  <= buf_data_nxt;
            buf_full  <= buf_full_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            signal    <= signal_nxt;
            bit_valid <= bit_valid_nxt;
            word_done <= word_done_nxt;
            in_ready  <= ~buf_full_nxt;
            busy      <= (state_nxt == SHIFT) | buf_full_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_serializer
// Description : Directed self-checking bench for seq_serializer (MSB-first
//               and LSB-first instances sharing one input stream).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_serializer;

    logic       clk;
    logic       rst;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;

    logic m_ready, m_signal, m_bit_valid, m_word_done, m_busy;
    logic l_ready, l_signal, l_bit_valid, l_word_done, l_busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (m_ready),
        .signal    (m_signal),
        .bit_valid (m_bit_valid),
        .word_done (m_word_done),
        .busy      (m_busy)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (l_ready),
        .signal    (l_signal),
        .bit_valid (l_bit_valid),
        .word_done (l_word_done),
        .busy      (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling / driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count 1001 patterns in an MSB-first-indexed stream of n bits.
    function automatic int count_1001(input logic [15:0] s, input int n);
        int c = 0;
        for (int i = n - 1; i >= 3; i--) begin
            if (s[i] == 1'b1 && s[i-1] == 1'b0 && s[i-2] == 1'b0 && s[i-3] == 1'b1)
                c++;
        end
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({m_signal, m_bit_valid, m_word_done, m_busy, m_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_outputs: got sig/bv/wd/busy/rdy=%b expected 00001",
                     {m_signal, m_bit_valid, m_word_done, m_busy, m_ready});
        end
        repeat (4) tick();
        n_checks++;
        if ({m_bit_valid, m_busy, m_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_quiet: got bv/busy/rdy=%b expected 001",
                     {m_bit_valid, m_busy, m_ready});
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp = 8'h99;
        logic [15:0] got = '0;
        int bad_bits = 0;
        int bad_wd = 0;
        in_data = 8'h99; in_valid = 1'b1;
        tick();                      // accept edge N
        in_valid = 1'b0;
        n_checks++;
        if ({m_ready, m_busy, m_bit_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL single_after_accept: got rdy/busy/bv=%b expected 010",
                     {m_ready, m_busy, m_bit_valid});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            got[7-i] = m_signal;
            if (m_signal !== exp[7-i] || m_bit_valid !== 1'b1) bad_bits++;
            if (m_word_done !== (i == 7)) bad_wd++;
        end
        n_checks++;
        if (bad_bits != 0) begin
            n_fail++;
            $display("FAIL single_bits: got stream %b expected %b", got[7:0], exp);
        end
        n_checks++;
        if (bad_wd != 0) begin
            n_fail++;
            $display("FAIL single_word_done: %0d cycles wrong, expected pulse only on bit 8", bad_wd);
        end
        n_checks++;
        if (count_1001(got, 8) != 2) begin
            n_fail++;
            $display("FAIL single_detect: got %0d 1001 hits expected 2", count_1001(got, 8));
        end
        tick();
        n_checks++;
        if ({m_signal, m_bit_valid, m_word_done, m_busy, m_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL single_end_idle: got sig/bv/wd/busy/rdy=%b expected 00001",
                     {m_signal, m_bit_valid, m_word_done, m_busy, m_ready});
        end
    endtask

    // Stream two words with in_valid held high; returns observed vectors.
    task automatic stream_two(input logic [7:0] w0, input logic [7:0] w1,
                              output logic [15:0] sig, output logic [15:0] bv,
                              output logic [15:0] wd, output logic [15:0] rdy);
        in_data = w0; in_valid = 1'b1;
        tick();                      // accept w0
        in_data = w1;
        for (int k = 0; k < 16; k++) begin
            tick();
            sig[15-k] = m_signal;
            bv[15-k]  = m_bit_valid;
            wd[15-k]  = m_word_done;
            rdy[15-k] = m_ready;
            if (k == 1) in_valid = 1'b0;   // w1 accepted on this edge
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] sig, bv, wd, rdy;
        stream_two(8'hA5, 8'h3C, sig, bv, wd, rdy);
        n_checks++;
        if (sig !== 16'hA53C) begin
            n_fail++;
            $display("FAIL b2b_bits: got %b expected %b", sig, 16'hA53C);
        end
        n_checks++;
        if (bv !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL b2b_bit_valid: got %b expected all ones", bv);
        end
        n_checks++;
        if (wd !== 16'b0000_0001_0000_0001) begin
            n_fail++;
            $display("FAIL b2b_word_done: got %b expected 0000000100000001", wd);
        end
        n_checks++;
        if (rdy !== 16'b1000_0000_1111_1111) begin
            n_fail++;
            $display("FAIL b2b_in_ready: got %b expected 1000000011111111", rdy);
        end
        tick();
        n_checks++;
        if ({m_bit_valid, m_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_end: got bv/busy=%b expected 00", {m_bit_valid, m_busy});
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] gl = '0;
        logic [7:0] gm = '0;
        in_data = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            gl[7-i] = l_signal;
            gm[7-i] = m_signal;
        end
        n_checks++;
        if (gl !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL lsb_bits: got %b expected 10000000", gl);
        end
        n_checks++;
        if (gm !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL msb_bits_01: got %b expected 00000001", gm);
        end
        n_checks++;
        if (l_word_done !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_word_done: got %b expected 1", l_word_done);
        end
        tick();
    endtask

    task automatic test_cross_word();
        logic [15:0] sig, bv, wd, rdy;
        stream_two(8'h01, 8'h20, sig, bv, wd, rdy);
        n_checks++;
        if (sig !== 16'h0120) begin
            n_fail++;
            $display("FAIL cross_bits: got %b expected %b", sig, 16'h0120);
        end
        n_checks++;
        if (count_1001(sig, 16) != 1) begin
            n_fail++;
            $display("FAIL cross_detect: got %0d 1001 hits expected 1", count_1001(sig, 16));
        end
        tick();
    endtask

    // Start A5 with 3C buffered and stop during bit 4 via clr or rst.
    task automatic abort_run(input bit use_rst, input string tag);
        int leaks = 0;
        in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_data = 8'h3C;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 1) in_valid = 1'b0;
        end
        if (use_rst) begin
            rst = 1'b0;
            #1;
        end else begin
            clr = 1'b1;
            tick();
            clr = 1'b0;
        end
        n_checks++;
        if ({m_signal, m_bit_valid, m_word_done, m_busy, m_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL %s_abort: got sig/bv/wd/busy/rdy=%b expected 00001", tag,
                     {m_signal, m_bit_valid, m_word_done, m_busy, m_ready});
        end
        if (use_rst) begin
            tick();
            rst = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m_bit_valid !== 1'b0 || m_signal !== 1'b0 || m_busy !== 1'b0) leaks++;
        end
        n_checks++;
        if (leaks != 0) begin
            n_fail++;
            $display("FAIL %s_discard: buffered word leaked on %0d cycles, expected 0", tag, leaks);
        end
    endtask

    task automatic test_abort();
        abort_run(1'b0, "clr");
        abort_run(1'b1, "rst");
        // A word offered on the clr edge is dropped.
        in_data = 8'hFF; in_valid = 1'b1; clr = 1'b1;
        tick();
        in_valid = 1'b0; clr = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({m_busy, m_bit_valid, m_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL clr_drop_accept: got busy/bv/rdy=%b expected 001",
                     {m_busy, m_bit_valid, m_ready});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_lsb_first();
        test_cross_word();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
